// File: rtl/ysyx_22040237_mcyc_ctrl_pkg.sv
// Shared definitions for the multi-cycle sequencer: state encodings, halt
// codes and default parameter values.
package ysyx_22040237_mcyc_ctrl_pkg;

    // Sequencer states. The encodings are visible on state_o for trace.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    // Reason reported on halt_code_o once the core stops.
    typedef enum logic [1:0] {
        HALT_EBREAK  = 2'd0,
        HALT_INVALID = 2'd1,
        HALT_TIMEOUT = 2'd2
    } halt_code_t;

    localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;
    localparam int          TIMEOUT_DEFAULT  = 255;
    localparam int          TO_W_DEFAULT     = 8;

    // States that wait on a memory-side handshake and therefore run the timer.
    function automatic logic is_wait_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEM);
    endfunction

endpackage

// File: rtl/ysyx_22040237_hs_timer.sv
// Handshake wait timer. Counts cycles spent waiting for a ready and flags
// when the count has reached the timeout limit.
module ysyx_22040237_hs_timer #(
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    logic [TO_W-1:0] count_q;

    assign expired = (count_q == TO_W'(TIMEOUT));

    // Wait counter: cleared outside handshake states, saturates at the limit.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours; blocking here would create
    // ordering-dependent simulation that no longer matches the netlist.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && !expired) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/ysyx_22040237_mcyc_ctrl.sv
// Multi-cycle sequencer for the RV64 core. Owns the PC, steps each
// instruction through FETCH/DECODE/EXEC/MEM/WB, gates register-file writes,
// halts on ebreak, illegal instruction or bus timeout, and keeps the cycle
// and retired-instruction counters.
module ysyx_22040237_mcyc_ctrl
    import ysyx_22040237_mcyc_ctrl_pkg::*;
#(
    parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          TIMEOUT  = TIMEOUT_DEFAULT,
    parameter int          TO_W     = TO_W_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    // instruction fetch handshake
    output logic        ifu_req_o,
    output logic [63:0] ifu_addr_o,
    input  logic        ifu_ready_i,
    output logic        ir_we_o,
    // decoder flags
    input  logic        invalid_inst_i,
    input  logic        is_ebreak_i,
    input  logic        is_load_i,
    input  logic        is_store_i,
    input  logic        rd_wr_en_i,
    input  logic [63:0] next_pc_i,
    // load/store handshake
    output logic        lsu_req_o,
    output logic        lsu_wr_o,
    input  logic        lsu_ready_i,
    // architectural side effects and status
    output logic        rf_wr_en_o,
    output logic [63:0] pc_o,
    output logic [2:0]  state_o,
    output logic        halt_o,
    output logic [1:0]  halt_code_o,
    output logic [63:0] cycle_cnt_o,
    output logic [63:0] instret_o
);

    state_t      state_q;
    logic [63:0] pc_q;
    logic        halt_q;
    halt_code_t  halt_code_q;
    logic        mem_wr_q;
    logic [63:0] cycle_q;
    logic [63:0] instret_q;

    logic        to_clr;
    logic        to_inc;
    logic        to_expired;
    logic        retire;

    // The timer runs only while a handshake is outstanding; leaving the wait
    // states clears it, so each FETCH/MEM entry starts from zero.
    assign to_clr = !is_wait_state(state_q);
    assign to_inc = ((state_q == ST_FETCH) && !ifu_ready_i) ||
                    ((state_q == ST_MEM)   && !lsu_ready_i);

    ysyx_22040237_hs_timer #(
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) u_hs_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (to_clr),
        .inc     (to_inc),
        .expired (to_expired)
    );

    // An instruction retires in WB, or in DECODE when it is a legal ebreak.
    assign retire = (state_q == ST_WB) ||
                    ((state_q == ST_DECODE) && !invalid_inst_i && is_ebreak_i);

    // Sequencer FSM: next state, PC update, halt status and the latched
    // store direction for the MEM handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            halt_q      <= 1'b0;
            halt_code_q <= HALT_EBREAK;
            mem_wr_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_FETCH;
                end
                ST_FETCH: begin
                    // A ready on the expiry cycle still completes the fetch.
                    if (ifu_ready_i) begin
                        state_q <= ST_DECODE;
                    end else if (to_expired) begin
                        state_q     <= ST_HALT;
                        halt_q      <= 1'b1;
                        halt_code_q <= HALT_TIMEOUT;
                    end
                end
                ST_DECODE: begin
                    if (invalid_inst_i) begin
                        state_q     <= ST_HALT;
                        halt_q      <= 1'b1;
                        halt_code_q <= HALT_INVALID;
                    end else if (is_ebreak_i) begin
                        state_q     <= ST_HALT;
                        halt_q      <= 1'b1;
                        halt_code_q <= HALT_EBREAK;
                    end else begin
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (is_load_i || is_store_i) begin
                        state_q  <= ST_MEM;
                        mem_wr_q <= is_store_i;
                    end else begin
                        state_q <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (lsu_ready_i) begin
                        state_q <= ST_WB;
                    end else if (to_expired) begin
                        state_q     <= ST_HALT;
                        halt_q      <= 1'b1;
                        halt_code_q <= HALT_TIMEOUT;
                    end
                end
                ST_WB: begin
                    pc_q    <= next_pc_i;
                    state_q <= ST_FETCH;
                end
                ST_HALT: begin
                    state_q <= ST_HALT;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Free-running cycle counter (frozen in HALT) and retired-instruction
    // counter; both wrap naturally at 2^64.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if (state_q != ST_HALT) begin
                cycle_q <= cycle_q + 64'd1;
            end
            if (retire) begin
                instret_q <= instret_q + 64'd1;
            end
        end
    end

    // Requests are pure decodes of the state register, so a ready input can
    // never loop back into a request, and reset drops them asynchronously.
    assign ifu_req_o   = (state_q == ST_FETCH);
    assign ifu_addr_o  = pc_q;
    assign ir_we_o     = (state_q == ST_FETCH) && ifu_ready_i;
    assign lsu_req_o   = (state_q == ST_MEM);
    assign lsu_wr_o    = (state_q == ST_MEM) && mem_wr_q;
    assign rf_wr_en_o  = (state_q == ST_WB) && rd_wr_en_i && !is_store_i;
    assign pc_o        = pc_q;
    assign state_o     = state_q;
    assign halt_o      = halt_q;
    assign halt_code_o = halt_code_q;
    assign cycle_cnt_o = cycle_q;
    assign instret_o   = instret_q;

endmodule

// File: tb/tb_ysyx_22040237_mcyc_ctrl.sv
// Self-checking bench for the multi-cycle sequencer: a per-cycle vector table
// for an addi/sd/ld/illegal program, then hand-written sequences for ebreak,
// fetch timeout, ready on the last allowed cycle and reset during MEM.
module tb_ysyx_22040237_mcyc_ctrl;

    localparam logic [63:0] P = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifu_req, ifu_ready, ir_we;
    logic [63:0] ifu_addr;
    logic        invalid_inst, is_ebreak, is_load, is_store, rd_wr_en;
    logic [63:0] next_pc;
    logic        lsu_req, lsu_wr, lsu_ready;
    logic        rf_wr_en;
    logic [63:0] pc;
    logic [2:0]  state;
    logic        halt;
    logic [1:0]  halt_code;
    logic [63:0] cycle_cnt, instret;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ysyx_22040237_mcyc_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ifu_req_o      (ifu_req),
        .ifu_addr_o     (ifu_addr),
        .ifu_ready_i    (ifu_ready),
        .ir_we_o        (ir_we),
        .invalid_inst_i (invalid_inst),
        .is_ebreak_i    (is_ebreak),
        .is_load_i      (is_load),
        .is_store_i     (is_store),
        .rd_wr_en_i     (rd_wr_en),
        .next_pc_i      (next_pc),
        .lsu_req_o      (lsu_req),
        .lsu_wr_o       (lsu_wr),
        .lsu_ready_i    (lsu_ready),
        .rf_wr_en_o     (rf_wr_en),
        .pc_o           (pc),
        .state_o        (state),
        .halt_o         (halt),
        .halt_code_o    (halt_code),
        .cycle_cnt_o    (cycle_cnt),
        .instret_o      (instret)
    );

    typedef struct {
        logic        ifu_rdy, lsu_rdy, inv, ebr, ld, st, rdw;
        logic [63:0] npc;
        logic [2:0]  e_state;
        logic        e_ifu_req, e_ir_we, e_lsu_req, e_lsu_wr, e_rf_wr, e_halt;
        logic [1:0]  e_hcode;
        logic [63:0] e_pc, e_instret, e_cyc;
    } vec_t;

    vec_t vecs [24];

    function automatic vec_t v(
        input logic ifu_rdy, lsu_rdy, inv, ebr, ld, st, rdw,
        input logic [63:0] npc, input logic [2:0] e_state,
        input logic e_ifu_req, e_ir_we, e_lsu_req, e_lsu_wr, e_rf_wr, e_halt,
        input logic [1:0] e_hcode, input logic [63:0] e_pc, e_instret, e_cyc);
        vec_t r;
        r.ifu_rdy = ifu_rdy; r.lsu_rdy = lsu_rdy; r.inv = inv; r.ebr = ebr;
        r.ld = ld; r.st = st; r.rdw = rdw; r.npc = npc; r.e_state = e_state;
        r.e_ifu_req = e_ifu_req; r.e_ir_we = e_ir_we; r.e_lsu_req = e_lsu_req;
        r.e_lsu_wr = e_lsu_wr; r.e_rf_wr = e_rf_wr; r.e_halt = e_halt;
        r.e_hcode = e_hcode; r.e_pc = e_pc; r.e_instret = e_instret; r.e_cyc = e_cyc;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ifu_r, lsu_r, inv, ebr, ld, st, rdw, input logic [63:0] npc);
        ifu_ready = ifu_r; lsu_ready = lsu_r; invalid_inst = inv; is_ebreak = ebr;
        is_load = ld; is_store = st; rd_wr_en = rdw; next_pc = npc;
        #1;
    endtask

    // Reset and release on a falling edge; returns in the IDLE cycle.
    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        int n;
        logic bad;

        rst_n = 1'b0;
        //            ifu lsu inv ebr ld st rdw npc          st  ifq irw lsq lsw rfw hlt hc pc        ret cyc
        vecs[0]  = v(0,0,0,0,0,0,0, '0,        3'd0, 0,0,0,0,0, 0,2'd0, P,        0, 0);
        vecs[1]  = v(1,0,0,0,0,0,0, '0,        3'd1, 1,1,0,0,0, 0,2'd0, P,        0, 1);
        vecs[2]  = v(0,0,0,0,0,0,1, '0,        3'd2, 0,0,0,0,0, 0,2'd0, P,        0, 2);
        vecs[3]  = v(0,0,0,0,0,0,1, '0,        3'd3, 0,0,0,0,0, 0,2'd0, P,        0, 3);
        vecs[4]  = v(0,0,0,0,0,0,1, P+4,       3'd5, 0,0,0,0,1, 0,2'd0, P,        0, 4);
        vecs[5]  = v(1,0,0,0,0,0,0, '0,        3'd1, 1,1,0,0,0, 0,2'd0, P+4,      1, 5);
        vecs[6]  = v(0,0,0,0,0,1,0, '0,        3'd2, 0,0,0,0,0, 0,2'd0, P+4,      1, 6);
        vecs[7]  = v(0,0,0,0,0,1,0, '0,        3'd3, 0,0,0,0,0, 0,2'd0, P+4,      1, 7);
        vecs[8]  = v(0,0,0,0,0,1,0, '0,        3'd4, 0,0,1,1,0, 0,2'd0, P+4,      1, 8);
        vecs[9]  = v(0,0,0,0,0,1,0, '0,        3'd4, 0,0,1,1,0, 0,2'd0, P+4,      1, 9);
        vecs[10] = v(0,0,0,0,0,1,0, '0,        3'd4, 0,0,1,1,0, 0,2'd0, P+4,      1, 10);
        vecs[11] = v(0,1,0,0,0,1,0, '0,        3'd4, 0,0,1,1,0, 0,2'd0, P+4,      1, 11);
        vecs[12] = v(0,0,0,0,0,1,1, P+8,       3'd5, 0,0,0,0,0, 0,2'd0, P+4,      1, 12);
        vecs[13] = v(0,0,0,0,0,0,0, '0,        3'd1, 1,0,0,0,0, 0,2'd0, P+8,      2, 13);
        vecs[14] = v(0,0,0,0,0,0,0, '0,        3'd1, 1,0,0,0,0, 0,2'd0, P+8,      2, 14);
        vecs[15] = v(1,0,0,0,0,0,0, '0,        3'd1, 1,1,0,0,0, 0,2'd0, P+8,      2, 15);
        vecs[16] = v(0,0,0,0,1,0,1, '0,        3'd2, 0,0,0,0,0, 0,2'd0, P+8,      2, 16);
        vecs[17] = v(0,0,0,0,1,0,1, '0,        3'd3, 0,0,0,0,0, 0,2'd0, P+8,      2, 17);
        vecs[18] = v(0,1,0,0,1,0,1, '0,        3'd4, 0,0,1,0,0, 0,2'd0, P+8,      2, 18);
        vecs[19] = v(0,0,0,0,1,0,1, P+'h100,   3'd5, 0,0,0,0,1, 0,2'd0, P+8,      2, 19);
        vecs[20] = v(1,0,0,0,0,0,0, '0,        3'd1, 1,1,0,0,0, 0,2'd0, P+'h100,  3, 20);
        vecs[21] = v(0,0,1,1,0,0,1, '0,        3'd2, 0,0,0,0,0, 0,2'd0, P+'h100,  3, 21);
        vecs[22] = v(1,1,0,0,1,1,1, P+'h200,   3'd6, 0,0,0,0,0, 1,2'd1, P+'h100,  3, 22);
        vecs[23] = v(1,1,0,0,1,1,1, P+'h200,   3'd6, 0,0,0,0,0, 1,2'd1, P+'h100,  3, 22);

        // addi, sd with three MEM waits, ld after two fetch waits, then an
        // instruction flagged both illegal and ebreak (illegal wins).
        do_reset();
        for (int i = 0; i < 24; i++) begin
            drive(vecs[i].ifu_rdy, vecs[i].lsu_rdy, vecs[i].inv, vecs[i].ebr,
                  vecs[i].ld, vecs[i].st, vecs[i].rdw, vecs[i].npc);
            check($sformatf("v%0d state", i),    state,     vecs[i].e_state);
            check($sformatf("v%0d ifu_req", i),  ifu_req,   vecs[i].e_ifu_req);
            check($sformatf("v%0d ifu_addr", i), ifu_addr,  vecs[i].e_pc);
            check($sformatf("v%0d ir_we", i),    ir_we,     vecs[i].e_ir_we);
            check($sformatf("v%0d lsu_req", i),  lsu_req,   vecs[i].e_lsu_req);
            check($sformatf("v%0d lsu_wr", i),   lsu_wr,    vecs[i].e_lsu_wr);
            check($sformatf("v%0d rf_wr_en", i), rf_wr_en,  vecs[i].e_rf_wr);
            check($sformatf("v%0d halt", i),     halt,      vecs[i].e_halt);
            check($sformatf("v%0d halt_code", i), halt_code, vecs[i].e_hcode);
            check($sformatf("v%0d pc", i),       pc,        vecs[i].e_pc);
            check($sformatf("v%0d instret", i),  instret,   vecs[i].e_instret);
            check($sformatf("v%0d cycle_cnt", i), cycle_cnt, vecs[i].e_cyc);
            tick();
        end

        // ebreak: halts with code 0, retires, then stays quiet for 20 cycles.
        do_reset();
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, '0);
        tick();
        drive(0, 0, 0, 1, 0, 0, 0, '0);
        tick();
        check("ebreak state", state, 3'd6);
        check("ebreak halt", halt, 1'b1);
        check("ebreak halt_code", halt_code, 2'd0);
        check("ebreak instret", instret, 64'd1);
        check("ebreak pc", pc, P);
        check("ebreak cycle_cnt", cycle_cnt, 64'd3);
        drive(1, 1, 0, 0, 1, 1, 1, P+4);
        for (int i = 0; i < 20; i++) begin
            bad = ifu_req | lsu_req | ir_we | rf_wr_en | lsu_wr;
            check($sformatf("ebreak quiet %0d", i), {63'd0, bad}, 64'd0);
            tick();
        end
        check("ebreak cycle_cnt frozen", cycle_cnt, 64'd3);
        check("ebreak instret held", instret, 64'd1);

        // Fetch never answered: 256 FETCH cycles (counter 0..255), then HALT.
        do_reset();
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, '0);
        n = 0;
        while (state == 3'd1 && n < 400) begin
            n++;
            tick();
        end
        check("timeout fetch cycles", 64'(n), 64'd256);
        check("timeout state", state, 3'd6);
        check("timeout halt", halt, 1'b1);
        check("timeout halt_code", halt_code, 2'd2);
        check("timeout pc", pc, P);

        // Ready arriving on the expiry cycle completes the fetch.
        do_reset();
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, '0);
        repeat (255) tick();
        check("late ready still fetching", state, 3'd1);
        drive(1, 0, 0, 0, 0, 0, 0, '0);
        check("late ready ir_we", ir_we, 1'b1);
        tick();
        check("late ready state", state, 3'd2);
        check("late ready no halt", halt, 1'b0);

        // Reset asserted while a store waits in MEM.
        do_reset();
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, '0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 0, '0);
        tick();
        tick();
        tick();
        tick();
        check("mid-mem lsu_req", lsu_req, 1'b1);
        check("mid-mem lsu_wr", lsu_wr, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async rst lsu_req", lsu_req, 1'b0);
        check("async rst lsu_wr", lsu_wr, 1'b0);
        check("async rst state", state, 3'd0);
        check("async rst pc", pc, P);
        check("async rst cycle_cnt", cycle_cnt, 64'd0);
        check("async rst instret", instret, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post rst state", state, 3'd0);
        tick();
        check("post rst fetch", state, 3'd1);
        check("post rst cycle_cnt", cycle_cnt, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
